// File: rtl/vtx_sequencer_pkg.sv
// Shared definitions for the vertex sequencer: coordinate width, default
// parameters, FSM state encoding and the packed pixel record held in the FIFO.
package vtx_sequencer_pkg;

    localparam int COORD_W        = 16;
    localparam int PIPE_LAT_DEF   = 4;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W_DEF      = 8;
    localparam int PIX_W          = 2 * COORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_VTX = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_CAPTURE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic               last;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } pix_t;

endpackage

// File: rtl/vtx_sequencer_if.sv
// Bundle of every non-clock/reset signal of the vertex sequencer.
//   slave  : sequencer side (inputs from mem_mgr, graphics_pipeline, rasteriser)
//   master : environment side (drives mem_mgr/pipeline/rasteriser signals)
interface vtx_sequencer_if
    import vtx_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic               iEnable;
    logic               iInitObj;
    logic [CNT_W-1:0]   iVtxCount;
    logic               iInitVtx;
    logic [COORD_W-1:0] iVertexX, iVertexY, iVertexZ;
    logic               oVtxReady;
    logic [COORD_W-1:0] oPipeVertexX, oPipeVertexY, oPipeVertexZ;
    logic [COORD_W-1:0] iPipeX, iPipeY;
    logic               iPipeExc;
    logic               oPixValid;
    logic               iPixReady;
    logic [COORD_W-1:0] oPixX, oPixY;
    logic               oPixLast;
    logic               oObjDone;
    logic               oBusy;
    logic [CNT_W-1:0]   oExcCount;
    logic               oOverrun;

    modport slave (
        input  iEnable, iInitObj, iVtxCount, iInitVtx, iVertexX, iVertexY, iVertexZ,
               iPipeX, iPipeY, iPipeExc, iPixReady,
        output oVtxReady, oPipeVertexX, oPipeVertexY, oPipeVertexZ,
               oPixValid, oPixX, oPixY, oPixLast, oObjDone, oBusy, oExcCount, oOverrun
    );

    modport master (
        output iEnable, iInitObj, iVtxCount, iInitVtx, iVertexX, iVertexY, iVertexZ,
               iPipeX, iPipeY, iPipeExc, iPixReady,
        input  oVtxReady, oPipeVertexX, oPipeVertexY, oPipeVertexZ,
               oPixValid, oPixX, oPixY, oPixLast, oObjDone, oBusy, oExcCount, oOverrun
    );
endinterface

// File: rtl/vtx_sequencer_pix_fifo.sv
// Show-ahead synchronous FIFO for projected pixels.
//   clk_i, rst_n_i : clock, async active-low reset
//   push_i, data_i : write side (no bypass: data visible the cycle after push)
//   pop_i          : consume head; ignored when empty
//   data_o         : head entry, forced to zero while empty
//   empty_o        : no entries
//   count_o        : number of stored entries
module vtx_sequencer_pix_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;
    logic             full;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !do_pop)      count_d = count_q + 1'b1;
        else if (!push_i && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    // The sequencer reserves a slot before accepting a vertex, so a push
    // into a full FIFO means the reservation logic is broken.
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push_i && full));

endmodule

// File: rtl/vtx_sequencer.sv
// Vertex sequencer between mem_mgr and graphics_pipeline.
// Accepts one vertex at a time, holds it on oPipeVertex* for PIPE_LAT cycles,
// then captures the projected X/Y into a pixel FIFO (or counts an exception).
//   iClock, iReset : clock, async active-low reset
//   bus (slave)    : mem_mgr handshake, pipeline vertex/result, pixel stream, status
//
// state       | meaning
// ST_IDLE     | no object active; waits for iInitObj
// ST_WAIT_VTX | object active; oVtxReady offered when a FIFO slot is free
// ST_SETTLE   | vertex held, waiting PIPE_LAT cycles for pipeline result
// ST_CAPTURE  | sample pipeline result, push pixel or count exception
module vtx_sequencer
    import vtx_sequencer_pkg::*;
#(
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input logic           iClock,
    input logic           iReset,
    vtx_sequencer_if.slave bus
);
    localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    seq_state_e         state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   exc_cnt_q, exc_cnt_d;
    logic               overrun_q, overrun_d;
    logic               obj_done_q, obj_done_d;
    logic [COORD_W-1:0] vtx_x_q, vtx_x_d, vtx_y_q, vtx_y_d, vtx_z_q, vtx_z_d;

    logic               vtx_ready;
    logic               push;
    pix_t               push_pix, head_pix;
    logic [PIX_W-1:0]   head_raw;
    logic               fifo_empty;
    logic [FCW-1:0]     fifo_count;

    assign vtx_ready = (state_q == ST_WAIT_VTX) && bus.iEnable && (fifo_count < FCW'(FIFO_DEPTH));

    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        remaining_d   = remaining_q;
        exc_cnt_d     = exc_cnt_q;
        overrun_d     = overrun_q;
        obj_done_d    = 1'b0;
        vtx_x_d       = vtx_x_q;
        vtx_y_d       = vtx_y_q;
        vtx_z_d       = vtx_z_q;
        push          = 1'b0;
        push_pix.last = (remaining_q == CNT_W'(1));
        push_pix.y    = bus.iPipeY;
        push_pix.x    = bus.iPipeX;

        if (bus.iInitVtx && !vtx_ready)             overrun_d = 1'b1;
        if (bus.iInitObj && (state_q != ST_IDLE))  overrun_d = 1'b1;

        // Dropping iEnable aborts the object silently; queued pixels remain.
        if ((state_q != ST_IDLE) && !bus.iEnable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iEnable && bus.iInitObj) begin
                        if (bus.iVtxCount == '0) begin
                            obj_done_d = 1'b1;
                        end else begin
                            remaining_d = bus.iVtxCount;
                            state_d     = ST_WAIT_VTX;
                        end
                    end
                end
                ST_WAIT_VTX: begin
                    if (bus.iInitVtx && vtx_ready) begin
                        vtx_x_d   = bus.iVertexX;
                        vtx_y_d   = bus.iVertexY;
                        vtx_z_d   = bus.iVertexZ;
                        lat_cnt_d = LAT_W'(PIPE_LAT - 1);
                        state_d   = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (lat_cnt_q == '0) state_d = ST_CAPTURE;
                    else                 lat_cnt_d = lat_cnt_q - 1'b1;
                end
                ST_CAPTURE: begin
                    if (bus.iPipeExc) begin
                        if (exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        obj_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_VTX;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            remaining_q <= '0;
            exc_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            obj_done_q  <= 1'b0;
            vtx_x_q     <= '0;
            vtx_y_q     <= '0;
            vtx_z_q     <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            remaining_q <= remaining_d;
            exc_cnt_q   <= exc_cnt_d;
            overrun_q   <= overrun_d;
            obj_done_q  <= obj_done_d;
            vtx_x_q     <= vtx_x_d;
            vtx_y_q     <= vtx_y_d;
            vtx_z_q     <= vtx_z_d;
        end
    end

    vtx_sequencer_pix_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk_i   (iClock),
        .rst_n_i (iReset),
        .push_i  (push),
        .data_i  (push_pix),
        .pop_i   (bus.iPixReady),
        .data_o  (head_raw),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_pix         = head_raw;
    assign bus.oVtxReady    = vtx_ready;
    assign bus.oPipeVertexX = vtx_x_q;
    assign bus.oPipeVertexY = vtx_y_q;
    assign bus.oPipeVertexZ = vtx_z_q;
    assign bus.oPixValid    = !fifo_empty;
    assign bus.oPixX        = head_pix.x;
    assign bus.oPixY        = head_pix.y;
    assign bus.oPixLast     = head_pix.last;
    assign bus.oObjDone     = obj_done_q;
    assign bus.oBusy        = (state_q != ST_IDLE);
    assign bus.oExcCount    = exc_cnt_q;
    assign bus.oOverrun     = overrun_q;

endmodule
